alu: RTL and testbench

- 32-bit integer ALU for the single-cycle RISC-V datapath: arithmetic, logic, shift, set-less-than and branch-compare operations.
- Opcode is a 4-bit control code from the ALU decoder.
- Result, carry and zero/branch flag are registered: one-cycle latency from operands to outputs.
- Z drives branch-taken logic; Y feeds writeback and address generation.

---
 rtl/alu_pkg.sv | 24 ++
 rtl/alu_core.sv | 93 +++++++++
 rtl/alu.sv | 45 ++++
 tb/tb_alu.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode encodings and default datapath width for the RISC-V ALU.
// The opcode values match the 4-bit control code produced by the ALU decoder.
package alu_pkg;

    localparam int DEFAULT_WIDTH = 32;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_SLL  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_SRL  = 4'b0100;
    localparam logic [3:0] OP_SRA  = 4'b0101;
    localparam logic [3:0] OP_OR   = 4'b0110;
    localparam logic [3:0] OP_AND  = 4'b0111;
    localparam logic [3:0] OP_SLT  = 4'b1000;
    localparam logic [3:0] OP_BNE  = 4'b1001;
    localparam logic [3:0] OP_BEQ  = 4'b1010;
    localparam logic [3:0] OP_SLTU = 4'b1011;
    localparam logic [3:0] OP_BLT  = 4'b1100;
    localparam logic [3:0] OP_BGE  = 4'b1101;
    localparam logic [3:0] OP_BLTU = 4'b1110;
    localparam logic [3:0] OP_BGEU = 4'b1111;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: computes the next result, carry and zero/branch flag.
// The top-level module registers these outputs.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [3:0]       opCode,
    input  logic [WIDTH-1:0] inpA,
    input  logic [WIDTH-1:0] inpB,
    output logic [WIDTH-1:0] y_next,
    output logic             c_next,
    output logic             z_next
);

    localparam int SHW = $clog2(WIDTH);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [SHW-1:0]   shamt;
    logic             lt_s;
    logic             lt_u;
    logic             eq;
    logic             cond;
    logic             is_branch;

    // The extra top bit of the difference is the borrow, which equals A <U B.
    assign sum   = {1'b0, inpA} + {1'b0, inpB};
    assign diff  = {1'b0, inpA} - {1'b0, inpB};
    assign shamt = inpB[SHW-1:0];
    assign lt_s  = $signed(inpA) < $signed(inpB);
    assign lt_u  = inpA < inpB;
    assign eq    = inpA == inpB;

    always_comb begin
        y_next    = '0;
        c_next    = 1'b0;
        cond      = 1'b0;
        is_branch = 1'b0;
        case (opCode)
            OP_ADD: begin
                y_next = sum[WIDTH-1:0];
                c_next = sum[WIDTH];
            end
            OP_SUB: begin
                y_next = diff[WIDTH-1:0];
                c_next = diff[WIDTH];
            end
            OP_SLL:  y_next = inpA << shamt;
            OP_XOR:  y_next = inpA ^ inpB;
            OP_SRL:  y_next = inpA >> shamt;
            OP_SRA:  y_next = WIDTH'($signed(inpA) >>> shamt);
            OP_OR:   y_next = inpA | inpB;
            OP_AND:  y_next = inpA & inpB;
            OP_SLT:  y_next = {{(WIDTH-1){1'b0}}, lt_s};
            OP_SLTU: y_next = {{(WIDTH-1){1'b0}}, lt_u};
            OP_BNE: begin
                is_branch = 1'b1;
                cond      = ~eq;
            end
            OP_BEQ: begin
                is_branch = 1'b1;
                cond      = eq;
            end
            OP_BLT: begin
                is_branch = 1'b1;
                cond      = lt_s;
            end
            OP_BGE: begin
                is_branch = 1'b1;
                cond      = ~lt_s;
            end
            OP_BLTU: begin
                is_branch = 1'b1;
                cond      = lt_u;
            end
            OP_BGEU: begin
                is_branch = 1'b1;
                cond      = ~lt_u;
            end
            default: y_next = '0;
        endcase

        // Branches report their condition on both Z and bit 0 of Y.
        if (is_branch) begin
            y_next = {{(WIDTH-1){1'b0}}, cond};
            z_next = cond;
        end else begin
            z_next = (y_next == '0);
        end
    end

endmodule

// File: rtl/alu.sv
// Registered 32-bit RISC-V ALU: one-cycle latency from operands to Y/C/Z.
// Synchronous active-high reset clears all outputs.
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       opCode,
    input  logic [WIDTH-1:0] inpA,
    input  logic [WIDTH-1:0] inpB,
    output logic             C,
    output logic             Z,
    output logic [WIDTH-1:0] Y
);

    logic [WIDTH-1:0] y_next;
    logic             c_next;
    logic             z_next;

    alu_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .opCode(opCode),
        .inpA  (inpA),
        .inpB  (inpB),
        .y_next(y_next),
        .c_next(c_next),
        .z_next(z_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            Y <= '0;
            C <= 1'b0;
            Z <= 1'b0;
        end else begin
            Y <= y_next;
            C <= c_next;
            Z <= z_next;
        end
    end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vector table, hold/latency checks,
// mid-stream reset and randomized operations against an arithmetic reference model.
module tb_alu;

    logic        clk;
    logic        rst;
    logic [3:0]  opCode;
    logic [31:0] inpA;
    logic [31:0] inpB;
    logic        C;
    logic        Z;
    logic [31:0] Y;

    int testsRun;
    int testsFailed;

    logic [31:0] prevY;
    logic        prevC;
    logic        prevZ;
    logic        prevValid;

    typedef struct {
        string       name;
        logic        rst;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] y;
        logic        c;
        logic        z;
    } vec_t;

    vec_t vecs[$];

    alu #(
        .WIDTH(32)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .opCode(opCode),
        .inpA  (inpA),
        .inpB  (inpB),
        .C     (C),
        .Z     (Z),
        .Y     (Y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model built from the operation definitions using wide integer arithmetic.
    function automatic void refModel(input logic [3:0] op, input logic [31:0] a,
                                     input logic [31:0] b, output logic [31:0] y,
                                     output logic c, output logic z);
        longint unsigned ua;
        longint unsigned ub;
        int              sa;
        int              sb;
        int unsigned     sh;
        bit              branch;
        bit              cnd;
        ua     = a;
        ub     = b;
        sa     = a;
        sb     = b;
        sh     = b % 32;
        y      = 0;
        c      = 0;
        branch = 0;
        cnd    = 0;
        case (op)
            4'd0: begin y = 32'(ua + ub); c = (ua + ub) > 64'hFFFF_FFFF; end
            4'd1: begin y = 32'(ua - ub); c = ua < ub; end
            4'd2: y = a << sh;
            4'd3: y = a ^ b;
            4'd4: y = a >> sh;
            4'd5: y = 32'(sa >>> sh);
            4'd6: y = a | b;
            4'd7: y = a & b;
            4'd8: y = (sa < sb) ? 1 : 0;
            4'd11: y = (ua < ub) ? 1 : 0;
            4'd9:  begin branch = 1; cnd = (a != b); end
            4'd10: begin branch = 1; cnd = (a == b); end
            4'd12: begin branch = 1; cnd = (sa < sb); end
            4'd13: begin branch = 1; cnd = (sa >= sb); end
            4'd14: begin branch = 1; cnd = (ua < ub); end
            default: begin branch = 1; cnd = (ua >= ub); end
        endcase
        if (branch) begin
            y = cnd ? 1 : 0;
            z = cnd;
        end else begin
            z = (y == 0);
        end
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] expY,
                               input logic expC, input logic expZ);
        testsRun++;
        if (Y !== expY || C !== expC || Z !== expZ) begin
            testsFailed++;
            $display("[TB] FAIL %s: got Y=%08h C=%b Z=%b, expected Y=%08h C=%b Z=%b",
                     name, Y, C, Z, expY, expC, expZ);
        end
    endtask

    // Drives one operation, optionally confirms outputs still hold the previous
    // result before the edge, then checks the registered result after the edge.
    task automatic applyStimulus(input string name, input logic r, input logic [3:0] op,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] expY, input logic expC,
                                 input logic expZ, input bit checkHold);
        rst    = r;
        opCode = op;
        inpA   = a;
        inpB   = b;
        #1;
        if (checkHold && prevValid)
            checkOutput({name, "_hold"}, prevY, prevC, prevZ);
        @(posedge clk);
        #1;
        checkOutput(name, expY, expC, expZ);
        prevY     = expY;
        prevC     = expC;
        prevZ     = expZ;
        prevValid = 1'b1;
    endtask

    function automatic vec_t mk(input string n, input logic r, input logic [3:0] op,
                                input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] y, input logic c, input logic z);
        vec_t v;
        v.name = n; v.rst = r; v.op = op; v.a = a; v.b = b;
        v.y = y; v.c = c; v.z = z;
        return v;
    endfunction

    initial begin
        logic [31:0] ey;
        logic        ec;
        logic        ez;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [3:0]  rop;

        testsRun    = 0;
        testsFailed = 0;
        prevValid   = 1'b0;
        rst         = 1'b1;
        opCode      = 4'h0;
        inpA        = '0;
        inpB        = '0;

        vecs.push_back(mk("reset0", 1, 4'h0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0, 0, 0));
        vecs.push_back(mk("reset1", 1, 4'h1, 32'h0000_0000, 32'h0000_0001, 32'h0, 0, 0));
        vecs.push_back(mk("xor", 0, 4'h3, 32'hD000_00A5, 32'hF000_00C3, 32'h2000_0066, 0, 0));
        vecs.push_back(mk("add_carry", 0, 4'h0, 32'h8000_00A9, 32'h8000_006F, 32'h0000_0118, 1, 0));
        vecs.push_back(mk("srl", 0, 4'h4, 32'h0000_0BD6, 32'd9, 32'd5, 0, 0));
        vecs.push_back(mk("sra", 0, 4'h5, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 0, 0));
        vecs.push_back(mk("slt_pos", 0, 4'h8, 32'h0000_00FD, 32'h0000_0100, 32'd1, 0, 0));
        vecs.push_back(mk("slt_neg", 0, 4'h8, 32'h8000_0000, 32'd1, 32'd1, 0, 0));
        vecs.push_back(mk("sltu", 0, 4'hB, 32'h8000_0000, 32'd1, 32'd0, 0, 1));
        vecs.push_back(mk("bne", 0, 4'h9, 32'h0012_1182, 32'h0011_1182, 32'd1, 0, 1));
        vecs.push_back(mk("beq", 0, 4'hA, 32'h0012_1182, 32'h0011_1182, 32'd0, 0, 0));
        vecs.push_back(mk("bge_eq", 0, 4'hD, 32'd5, 32'd5, 32'd1, 0, 1));
        vecs.push_back(mk("add_min", 0, 4'h0, 32'h8000_0000, 32'h8000_0000, 32'd0, 1, 1));
        vecs.push_back(mk("sub_eq", 0, 4'h1, 32'd7, 32'd7, 32'd0, 0, 1));
        vecs.push_back(mk("sub_borrow", 0, 4'h1, 32'd1, 32'd2, 32'hFFFF_FFFF, 1, 0));
        vecs.push_back(mk("sll_upper_ignored", 0, 4'h2, 32'd1, 32'h0000_0020, 32'd1, 0, 0));
        vecs.push_back(mk("sll_31", 0, 4'h2, 32'd1, 32'd31, 32'h8000_0000, 0, 0));
        vecs.push_back(mk("blt_neg", 0, 4'hC, 32'hFFFF_FFFF, 32'd0, 32'd1, 0, 1));
        vecs.push_back(mk("bltu_neg", 0, 4'hE, 32'hFFFF_FFFF, 32'd0, 32'd0, 0, 0));
        vecs.push_back(mk("bgeu_max", 0, 4'hF, 32'hFFFF_FFFF, 32'd0, 32'd1, 0, 1));
        vecs.push_back(mk("and_zero", 0, 4'h7, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'd0, 0, 1));
        vecs.push_back(mk("or", 0, 4'h6, 32'hF0F0_0000, 32'h0000_0F0F, 32'hF0F0_0F0F, 0, 0));

        foreach (vecs[i])
            applyStimulus(vecs[i].name, vecs[i].rst, vecs[i].op, vecs[i].a, vecs[i].b,
                          vecs[i].y, vecs[i].c, vecs[i].z, 1'b1);

        // Back-to-back: every opcode in turn, with a reset asserted partway through.
        for (int i = 0; i < 16; i++) begin
            ra  = $urandom;
            rb  = (i % 3 == 0) ? ra : $urandom;
            rop = 4'(i);
            if (i == 9) begin
                applyStimulus("b2b_reset", 1'b1, rop, ra, rb, 32'd0, 1'b0, 1'b0, 1'b1);
            end else begin
                refModel(rop, ra, rb, ey, ec, ez);
                applyStimulus($sformatf("b2b_op%0d", i), 1'b0, rop, ra, rb, ey, ec, ez, 1'b1);
            end
        end

        // Random operations, biased toward sign boundaries and equal operands.
        for (int i = 0; i < 300; i++) begin
            rop = 4'($urandom_range(0, 15));
            case ($urandom_range(0, 5))
                0: ra = 32'h8000_0000;
                1: ra = 32'h0000_0000;
                2: ra = 32'hFFFF_FFFF;
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0: rb = ra;
                1: rb = 32'h7FFF_FFFF;
                2: rb = $urandom_range(0, 40);
                default: rb = $urandom;
            endcase
            refModel(rop, ra, rb, ey, ec, ez);
            applyStimulus($sformatf("rand_op%0d", rop), 1'b0, rop, ra, rb, ey, ec, ez, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
